temp_bcd_formatter: RTL

Converts the sensor's binary Celsius and Fahrenheit readings into debounced, latched BCD digits for the LED matrix text renderer. It sits between the I2C sensor reader / C-to-F converter and the matrix driver, in the 25 MHz `clk` domain. Inputs are sampled periodically and accepted only after they stay stable for several samples. Accepted values are converted with a sequential double-dabble engine. Results are held steady so the display never shows a half-updated reading.

---
 rtl/temp_fmt_pkg.sv | 41 ++++
 rtl/bin8_to_bcd_seq.sv | 49 ++++
 rtl/temp_bcd_formatter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/temp_fmt_pkg.sv
// Shared types and helpers for the temperature BCD formatter: FSM states,
// widths and the double-dabble step used by the sequential converter.
package temp_fmt_pkg;

  localparam int BIN_W    = 8;
  localparam int BCD_W    = 12;
  localparam int DD_W     = BCD_W + BIN_W;
  localparam int DD_STEPS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_C = 2'd1,
    ST_CONV_F = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // One double-dabble iteration: adjust every BCD nibble >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[BIN_W + 4*i +: 4] >= 4'd5) begin
        r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4] + 4'd3;
      end else begin
        r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4];
      end
    end
    return {r[DD_W-2:0], 1'b0};
  endfunction

  function automatic logic [1:0] digit_count(input logic [BIN_W-1:0] v);
    if (v < 8'd10) begin
      return 2'd1;
    end else if (v < 8'd100) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/bin8_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter. A start pulse loads the
// operand and performs the first step; done is high once all steps are done.
module bin8_to_bcd_seq
  import temp_fmt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam logic [3:0] LAST_STEP = 4'(DD_STEPS);

  logic [DD_W-1:0] sh_q, sh_d;
  logic [3:0]      cnt_q, cnt_d;

  // Next shift-register contents and step count.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sh_d  = dd_step({{BCD_W{1'b0}}, bin_i});
      cnt_d = 4'd1;
    end else if ((cnt_q != 4'd0) && (cnt_q < LAST_STEP)) begin
      sh_d  = dd_step(sh_q);
      cnt_d = cnt_q + 4'd1;
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= {DD_W{1'b0}};
      cnt_q <= 4'd0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST_STEP);
  assign bcd_o  = sh_q[DD_W-1 -: BCD_W];

endmodule

// File: rtl/temp_bcd_formatter.sv
// Debounces Celsius/Fahrenheit readings, converts accepted values to BCD with
// one shared double-dabble engine and publishes them atomically with a pulse.
module temp_bcd_formatter
  import temp_fmt_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 250000,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  temp_c,
  input  logic [BIN_W-1:0]  temp_f,
  output logic [BCD_W-1:0]  c_bcd,
  output logic [BCD_W-1:0]  f_bcd,
  output logic [1:0]        c_digits,
  output logic [1:0]        f_digits,
  output logic              valid,
  output logic              update
);

  localparam int         PW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0] S_TGT  = 4'(STABLE_CNT);

  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [2*BIN_W-1:0]   prev_q, prev_d, cand_q, cand_d, work_q, work_d;
  logic [2*BIN_W-1:0]   committed_q, committed_d, live_s;
  logic [3:0]           stab_q, stab_d;
  logic                 req_q, req_d, pending_q, pending_d;
  state_e               state_q, state_d;
  logic [BCD_W-1:0]     c_res_q, c_res_d, f_res_q, f_res_d;
  logic [BCD_W-1:0]     c_bcd_q, c_bcd_d, f_bcd_q, f_bcd_d;
  logic [1:0]           c_dig_q, c_dig_d, f_dig_q, f_dig_d;
  logic                 valid_q, valid_d, update_q, update_d;
  logic                 tick_s, reach_s, req_s, start_s, done_s;
  logic [BIN_W-1:0]     bin_s;
  logic [BCD_W-1:0]     bcd_s;

  assign live_s = {temp_c, temp_f};
  assign tick_s = (pcnt_q == P_LAST);

  bin8_to_bcd_seq u_dd (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_s),
    .bin_i   (bin_s),
    .done_o  (done_s),
    .bcd_o   (bcd_s)
  );

  // Prescaler, debounce, request generation and conversion sequencing.
  always_comb begin
    pcnt_d      = pcnt_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    cand_d      = cand_q;
    pending_d   = pending_q;
    state_d     = state_q;
    work_d      = work_q;
    c_res_d     = c_res_q;
    f_res_d     = f_res_q;
    committed_d = committed_q;
    c_bcd_d     = c_bcd_q;
    f_bcd_d     = f_bcd_q;
    c_dig_d     = c_dig_q;
    f_dig_d     = f_dig_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    start_s     = 1'b0;
    bin_s       = work_q[BIN_W-1:0];

    if (tick_s) begin
      pcnt_d = {PW{1'b0}};
      prev_d = live_s;
      if (live_s == prev_q) begin
        stab_d = (stab_q == S_TGT) ? stab_q : stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
      end
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    reach_s = tick_s && (stab_d == S_TGT) && ((stab_q != S_TGT) || (S_TGT == 4'd1));
    req_s   = reach_s && ((live_s != committed_q) || !valid_q);
    req_d   = req_s;
    // Only accepted values reach cand, so a queued request never converts noise.
    if (req_s) begin
      cand_d = live_s;
    end else begin
      cand_d = cand_q;
    end

    if (req_q && (state_q != ST_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_q || pending_q) begin
          state_d   = ST_CONV_C;
          work_d    = cand_q;
          start_s   = 1'b1;
          bin_s     = cand_q[2*BIN_W-1:BIN_W];
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV_C: begin
        if (done_s) begin
          c_res_d = bcd_s;
          start_s = 1'b1;
          bin_s   = work_q[BIN_W-1:0];
          state_d = ST_CONV_F;
        end else begin
          state_d = ST_CONV_C;
        end
      end
      ST_CONV_F: begin
        if (done_s) begin
          f_res_d = bcd_s;
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_CONV_F;
        end
      end
      ST_COMMIT: begin
        c_bcd_d     = c_res_q;
        f_bcd_d     = f_res_q;
        c_dig_d     = digit_count(work_q[2*BIN_W-1:BIN_W]);
        f_dig_d     = digit_count(work_q[BIN_W-1:0]);
        committed_d = work_q;
        valid_d     = 1'b1;
        update_d    = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset also discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q      <= {PW{1'b0}};
      prev_q      <= {2*BIN_W{1'b0}};
      stab_q      <= 4'd0;
      req_q       <= 1'b0;
      cand_q      <= {2*BIN_W{1'b0}};
      pending_q   <= 1'b0;
      state_q     <= ST_IDLE;
      work_q      <= {2*BIN_W{1'b0}};
      c_res_q     <= {BCD_W{1'b0}};
      f_res_q     <= {BCD_W{1'b0}};
      committed_q <= {2*BIN_W{1'b0}};
      c_bcd_q     <= {BCD_W{1'b0}};
      f_bcd_q     <= {BCD_W{1'b0}};
      c_dig_q     <= 2'd0;
      f_dig_q     <= 2'd0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      req_q       <= req_d;
      cand_q      <= cand_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      work_q      <= work_d;
      c_res_q     <= c_res_d;
      f_res_q     <= f_res_d;
      committed_q <= committed_d;
      c_bcd_q     <= c_bcd_d;
      f_bcd_q     <= f_bcd_d;
      c_dig_q     <= c_dig_d;
      f_dig_q     <= f_dig_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
    end
  end

  assign c_bcd    = c_bcd_q;
  assign f_bcd    = f_bcd_q;
  assign c_digits = c_dig_q;
  assign f_digits = f_dig_q;
  assign valid    = valid_q;
  assign update   = update_q;

endmodule
